// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the GMII transmit frame sequencer.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        DROP,
        IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [7:0]  PAD_BYTE      = 8'h00;
    localparam int unsigned FCS_LEN       = 4;

endpackage

// File: rtl/gmii_tx_fcs_ctrl.sv
// GMII transmit frame sequencer: preamble, SFD, payload, pad, FCS and inter-frame gap,
// steering an external crc32_8023 through its load/calc/enable controls.
module gmii_tx_fcs_ctrl
    import eth_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_CYCLES   = 12,
    parameter int unsigned CNT_W        = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] crc_d,
    output logic       crc_load_init,
    output logic       crc_calc,
    output logic       crc_d_valid,
    input  logic [7:0] crc_byte,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       frame_done,
    output logic       underrun_err
);

    localparam int unsigned SEQ_W = 8;

    // The IDLE-exit edge already emits the first preamble byte, so PRE covers the rest.
    localparam logic [SEQ_W-1:0] PRE_LAST = SEQ_W'(PREAMBLE_LEN - 2);
    localparam logic [SEQ_W-1:0] FCS_LAST = SEQ_W'(FCS_LEN - 1);
    localparam logic [SEQ_W-1:0] IFG_LAST = SEQ_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W:0]   MIN_FRAME_W = (CNT_W + 1)'(MIN_FRAME);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;

    logic [7:0] txd_q, txd_d;
    logic       tx_en_q, tx_en_d;
    logic       tx_er_q, tx_er_d;
    logic       done_q, done_d;
    logic       under_q, under_d;

    // One extra bit so the pad decision stays correct once byte_cnt saturates.
    logic [CNT_W:0]   cnt_plus1;
    logic [CNT_W-1:0] byte_cnt_sat;

    assign cnt_plus1    = {1'b0, byte_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign byte_cnt_sat = (&byte_cnt_q) ? byte_cnt_q : cnt_plus1[CNT_W-1:0];

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        seq_cnt_d     = seq_cnt_q;
        txd_d         = 8'h00;
        tx_en_d       = 1'b0;
        tx_er_d       = 1'b0;
        done_d        = 1'b0;
        under_d       = 1'b0;
        in_ready      = 1'b0;
        crc_d         = 8'h00;
        crc_load_init = 1'b0;
        crc_calc      = 1'b0;
        crc_d_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                byte_cnt_d = '0;
                seq_cnt_d  = '0;
                if (in_valid) begin
                    state_d = PRE;
                    tx_en_d = 1'b1;
                    txd_d   = PREAMBLE_BYTE;
                end
            end
            PRE: begin
                tx_en_d = 1'b1;
                txd_d   = PREAMBLE_BYTE;
                if (seq_cnt_q == PRE_LAST) begin
                    seq_cnt_d = '0;
                    state_d   = SFD;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            SFD: begin
                tx_en_d       = 1'b1;
                txd_d         = SFD_BYTE;
                crc_load_init = 1'b1;
                state_d       = DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                tx_en_d  = 1'b1;
                if (in_valid) begin
                    txd_d       = in_data;
                    crc_d       = in_data;
                    crc_calc    = 1'b1;
                    crc_d_valid = 1'b1;
                    byte_cnt_d  = byte_cnt_sat;
                    if (in_last) begin
                        state_d = (cnt_plus1 < MIN_FRAME_W) ? PAD : FCS;
                    end
                end else begin
                    // Source starved mid-frame: poison the frame on the wire.
                    tx_er_d = 1'b1;
                    under_d = 1'b1;
                    state_d = in_last ? IFG : DROP;
                end
            end
            PAD: begin
                tx_en_d     = 1'b1;
                txd_d       = PAD_BYTE;
                crc_d       = PAD_BYTE;
                crc_calc    = 1'b1;
                crc_d_valid = 1'b1;
                byte_cnt_d  = byte_cnt_sat;
                if (cnt_plus1 >= MIN_FRAME_W) begin
                    state_d = FCS;
                end
            end
            FCS: begin
                tx_en_d     = 1'b1;
                txd_d       = crc_byte;
                crc_d_valid = 1'b1;
                if (seq_cnt_q == FCS_LAST) begin
                    seq_cnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = IFG;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = IFG;
                end
            end
            IFG: begin
                if (seq_cnt_q == IFG_LAST) begin
                    seq_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            seq_cnt_q  <= '0;
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            done_q     <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            seq_cnt_q  <= seq_cnt_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            done_q     <= done_d;
            under_q    <= under_d;
        end
    end

    assign gmii_txd     = txd_q;
    assign gmii_tx_en   = tx_en_q;
    assign gmii_tx_er   = tx_er_q;
    assign frame_done   = done_q;
    assign underrun_err = under_q;

endmodule

// File: tb/tb_gmii_tx_fcs_ctrl.sv
// Directed bench for gmii_tx_fcs_ctrl with a behavioural crc32_8023 beside it.
module tb_gmii_tx_fcs_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] crc_d;
    logic       crc_load_init;
    logic       crc_calc;
    logic       crc_d_valid;
    logic [7:0] crc_byte;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       frame_done;
    logic       underrun_err;

    int n_vec = 0;
    int n_err = 0;

    gmii_tx_fcs_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .crc_d        (crc_d),
        .crc_load_init(crc_load_init),
        .crc_calc     (crc_calc),
        .crc_d_valid  (crc_d_valid),
        .crc_byte     (crc_byte),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .frame_done   (frame_done),
        .underrun_err (underrun_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reflected IEEE 802.3 CRC-32, one byte LSB first.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // crc32_8023 stand-in: FCS bytes come out complemented, low byte first.
    logic [31:0] crc_reg;
    always @(posedge clk) begin
        if (!reset || crc_load_init) crc_reg <= 32'hFFFFFFFF;
        else if (crc_d_valid) crc_reg <= crc_calc ? crc_upd(crc_reg, crc_d)
                                                  : {8'hFF, crc_reg[31:8]};
    end
    assign crc_byte = ~crc_reg[7:0];

    typedef struct packed {
        logic       en;
        logic       er;
        logic       fd;
        logic       ue;
        logic       li;
        logic       dv;
        logic       rdy;
        logic [7:0] txd;
    } samp_t;

    samp_t      rec[$];
    bit         rec_on = 1'b0;
    logic [7:0] pay[$];

    initial begin
        samp_t s;
        forever begin
            @(negedge clk);
            #2;
            if (rec_on) begin
                s.en = gmii_tx_en;  s.er = gmii_tx_er;  s.fd = frame_done;
                s.ue = underrun_err; s.li = crc_load_init; s.dv = crc_d_valid;
                s.rdy = in_ready;   s.txd = gmii_txd;
                rec.push_back(s);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Streams pay[]; optionally withholds in_valid for one cycle once stall_after bytes went.
    task automatic send_frame(input int stall_after);
        int idx;
        int guard;
        bit hs;
        bit stalled;
        idx = 0; guard = 0; stalled = 1'b0;
        while (idx < pay.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (idx == stall_after && !stalled) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                stalled  = 1'b1;
                @(posedge clk);
                continue;
            end
            in_valid = 1'b1;
            in_data  = pay[idx];
            in_last  = (idx == pay.size() - 1);
            hs = in_ready;
            @(posedge clk);
            if (hs) idx++;
        end
        if (guard >= 4000) check_eq("send_timeout", idx, pay.size());
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Checks the frame built from pay[] starting at the first tx_en at or after 'from'.
    task automatic check_frame(input string nm, input int from, output int s, output int e);
        logic [7:0]  exp[$];
        logic [31:0] c;
        int n, cfd, cli, cdv, cer;
        exp = {};
        repeat (7) exp.push_back(8'h55);
        exp.push_back(8'hD5);
        foreach (pay[i]) exp.push_back(pay[i]);
        while (exp.size() < 68) exp.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < exp.size(); i++) c = crc_upd(c, exp[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) exp.push_back(c[8*k +: 8]);

        s = -1;
        for (int i = from; i < rec.size(); i++) begin
            if (rec[i].en) begin s = i; break; end
        end
        if (s < 0) begin
            check_eq({nm, ":start"}, 0, 1);
            s = from; e = from;
            return;
        end
        n = 0;
        while (s + n < rec.size() && rec[s+n].en) n++;
        e = s + n;
        check_eq({nm, ":en_len"}, n, exp.size());
        for (int i = 0; i < exp.size() && i < n; i++)
            check_eq($sformatf("%s:b%0d", nm, i), rec[s+i].txd, exp[i]);
        cfd = 0; cli = 0; cdv = 0; cer = 0;
        for (int i = s; i < e; i++) begin
            cfd += rec[i].fd; cli += rec[i].li; cdv += rec[i].dv; cer += rec[i].er;
        end
        check_eq({nm, ":done_cnt"}, cfd, 1);
        check_eq({nm, ":done_last"}, rec[e-1].fd, 1);
        check_eq({nm, ":er_cnt"}, cer, 0);
        check_eq({nm, ":load_cnt"}, cli, 1);
        // Preset happens in the SFD state, the cycle before D5 shows on the registered pins.
        check_eq({nm, ":load_at_sfd"}, rec[s+6].li, 1);
        check_eq({nm, ":dv_cnt"}, cdv, exp.size() - 8);
    endtask

    initial begin
        logic [7:0] pay_a[$];
        logic [7:0] pay_b[$];
        int s1, e1, s2, e2, ur, cnt, cfd, cdv, cer, cue;
        bit found;

        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", {gmii_txd, crc_d, gmii_tx_en, gmii_tx_er, in_ready,
                                crc_load_init, crc_calc, crc_d_valid, frame_done,
                                underrun_err}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("idle_en%0d", i), gmii_tx_en, 0);
        end

        // Short frame pads to the minimum length.
        pay = {8'haa, 8'hbb, 8'hcc, 8'hdd};
        rec = {}; rec_on = 1'b1;
        send_frame(-1);
        idle_in();
        repeat (90) @(negedge clk);
        check_frame("f4", 0, s1, e1);

        // 64-byte payload needs no padding.
        pay = {};
        for (int i = 0; i < 64; i++) pay.push_back(8'(i));
        rec = {};
        send_frame(-1);
        idle_in();
        repeat (30) @(negedge clk);
        check_frame("f64", 0, s1, e1);

        // Back-to-back with in_valid held: exact gap and re-initialised CRC.
        pay_a = {};
        for (int i = 0; i < 61; i++) pay_a.push_back(8'(i * 3 + 1));
        pay_b = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc};
        rec = {};
        pay = pay_a;
        send_frame(-1);
        pay = pay_b;
        send_frame(-1);
        idle_in();
        repeat (90) @(negedge clk);
        pay = pay_a;
        check_frame("b2b_a", 0, s1, e1);
        pay = pay_b;
        check_frame("b2b_b", e1, s2, e2);
        check_eq("b2b_gap", s2 - e1, 12);

        // Underrun after byte 10 of 30, followed immediately by a clean frame.
        pay = {};
        for (int i = 0; i < 30; i++) pay.push_back(8'(8'h80 + i));
        rec = {};
        send_frame(10);
        pay = {8'h01, 8'h02, 8'h03};
        send_frame(-1);
        idle_in();
        repeat (90) @(negedge clk);
        s1 = -1; ur = -1;
        for (int i = 0; i < rec.size(); i++) if (rec[i].en) begin s1 = i; break; end
        for (int i = 0; i < rec.size(); i++) if (rec[i].er) begin ur = i; break; end
        if (s1 < 0 || ur < 0) begin
            check_eq("ur_found", (s1 >= 0) && (ur >= 0), 1);
        end else begin
            check_eq("ur_pos", ur - s1, 18);
            check_eq("ur_cycle", {rec[ur].en, rec[ur].ue, rec[ur].txd}, {2'b11, 8'h00});
            for (int i = 0; i < 10; i++)
                check_eq($sformatf("ur:b%0d", i), rec[s1+8+i].txd, 8'(8'h80 + i));
            s2 = -1;
            for (int i = ur + 1; i < rec.size(); i++) if (rec[i].en) begin s2 = i; break; end
            check_eq("ur_gap", s2 - ur - 1, 20 + 12);
            cfd = 0; cdv = 0; cer = 0; cue = 0;
            for (int i = s1; i < s2 && i < rec.size(); i++) begin
                cfd += rec[i].fd; cdv += rec[i].dv; cer += rec[i].er; cue += rec[i].ue;
            end
            check_eq("ur_done", cfd, 0);
            check_eq("ur_dv", cdv, 10);
            check_eq("ur_er_cnt", cer, 1);
            check_eq("ur_ue_cnt", cue, 1);
            check_frame("ur_next", ur + 1, s2, e2);
        end

        // Reset while the second FCS byte is on the pins.
        pay = {8'h01, 8'h02, 8'h03};
        rec = {};
        send_frame(-1);
        idle_in();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            #3;
            cnt = 0;
            foreach (rec[i]) cnt += rec[i].en;
            if (cnt == 70) found = 1'b1;
        end
        check_eq("rst_reach", found, 1);
        reset = 1'b0;
        @(negedge clk);
        #3;
        check_eq("rst_mid_outs", {gmii_txd, crc_d, gmii_tx_en, gmii_tx_er, in_ready,
                                  crc_load_init, crc_calc, crc_d_valid, frame_done,
                                  underrun_err}, 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        cfd = 0;
        foreach (rec[i]) cfd += rec[i].fd;
        check_eq("rst_no_done", cfd, 0);

        pay = {8'hde, 8'had, 8'hbe, 8'hef, 8'h42};
        rec = {};
        send_frame(-1);
        idle_in();
        repeat (90) @(negedge clk);
        check_frame("post_rst", 0, s1, e1);

        rec_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gmii_tx_fcs_ctrl.md
Name: gmii_tx_fcs_ctrl

Overview:
Transmit-side frame sequencer for the GMII MAC. It converts a byte stream with valid/ready/last into a complete GMII frame: 7x preamble, SFD, payload, zero padding to the minimum frame length, then a 4-byte FCS, followed by an enforced inter-frame gap. It sequences an external crc32_8023 instance through its load_init, calc and d_valid controls and reads back the FCS bytes. It sits between the switch egress queue and the GMII TX pins.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD
MIN_FRAME, 60, minimum bytes (payload + pad) before the FCS
IFG_CYCLES, 12, idle cycles between frames, with tx_en=0
CNT_W, 11, width of the byte counter, which saturates at all-ones

Ports:
clk  in  1  system clock, 125 MHz GMII TX clock
reset  in  1  synchronous, active-low reset
in_data  in  8  payload byte
in_valid  in  1  in_data valid
in_last  in  1  final payload byte of the frame
in_ready  out  1  byte accepted when in_valid&in_ready
crc_d  out  8  byte to the CRC (d)
crc_load_init  out  1  CRC preset
crc_calc  out  1  1=accumulate, 0=shift out FCS
crc_d_valid  out  1  CRC enable
crc_byte  in  8  CRC output byte (crc), combinational from crc_reg
gmii_txd  out  8  registered TX data
gmii_tx_en  out  1  registered TX enable
gmii_tx_er  out  1  registered TX error
frame_done  out  1  1-cycle pulse on the last FCS byte
underrun_err  out  1  1-cycle pulse on an abort

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, counters=0. gmii_txd/tx_en/tx_er, in_ready, all crc_* outputs, frame_done and underrun_err are all 0. Reset applied mid-frame truncates the frame with tx_er=0. The CRC shares the same reset.
- GMII outputs are registered. crc_* outputs and in_ready decode combinationally from state and the current inputs.
- IDLE: in_ready=0. If in_valid=1, then at the next edge the state goes to PRE and tx_en=1, txd=0x55. Latency from in_valid to tx_en is one cycle.
- PRE: outputs PREAMBLE_LEN cycles of 0x55, then SFD.
- SFD: outputs txd=0xD5 for one cycle. crc_load_init=1 during that cycle.
- DATA:
  - in_ready=1.
  - On a handshake: txd<=in_data, crc_d=in_data, crc_calc=1, crc_d_valid=1. byte_cnt increments and saturates.
  - in_last with byte_cnt+1<MIN_FRAME goes to PAD. Otherwise it goes to FCS.
  - in_valid=0 in DATA is an underrun: tx_en=1, tx_er=1, txd=0x00 for one cycle, underrun_err pulses. If that cycle's in_last had not yet been seen, go to DROP, else go to IFG.
- PAD: txd=0x00, crc_d=0x00, crc_calc=1, crc_d_valid=1 each cycle until byte_cnt=MIN_FRAME. in_ready=0.
- FCS: 4 cycles with crc_calc=0, crc_d_valid=1, crc_d=0, txd<=crc_byte. The CRC shifts one byte per edge. frame_done pulses with the 4th byte, then go to IFG.
- DROP: in_ready=1, tx_en=0. Bytes are discarded until in_last is accepted, then go to IFG.
- IFG: tx_en=0, in_ready=0 for IFG_CYCLES cycles, then IDLE. A held in_valid is honoured only after the gap.
- crc_load_init, crc_calc and crc_d_valid are never asserted in IDLE, PRE, DROP or IFG.
- A 1-byte frame pads to 60. A frame that reaches the counter saturation still appends a correct FCS.

Decomposition:
- Package eth_tx_pkg holds:
  - the state enum: IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PAD_BYTE=8'h00, FCS_LEN=4
- No sub-module. The counters stay inline. crc32_8023 is instantiated beside this block in the TX MAC top, not inside it.

Test Plan:
- Reset: hold reset=0 for 2 edges -> all outputs are 0 and in_ready=0. After release, with in_valid=0, tx_en stays 0.
- Frame aa bb cc dd (in_last on dd) -> 7x55, D5, aa bb cc dd, 56x00, then 4 FCS bytes equal to the software CRC32 of the 60 bytes. tx_en is high for exactly 72 cycles and frame_done pulses once.
- 64-byte incrementing payload -> no pad. tx_en is high for 76 cycles and the FCS matches the model. The crc_load_init pulse coincides with the SFD.
- Two back-to-back frames with in_valid held -> exactly 12 cycles of tx_en=0 between frames. The second FCS is correct, showing the CRC was re-initialised.
- Underrun: in_valid drops after byte 10 of a 30-byte frame -> one cycle of tx_en=1, tx_er=1, txd=00, and underrun_err pulses. The remaining 20 bytes are accepted but not transmitted, followed by 12 IFG cycles.
- Reset during the 2nd FCS byte -> at the next edge tx_en=0 and state=IDLE. The next frame transmits with a correct FCS.
